// File: rtl/fpmul_result_fifo_if.sv
// fpmul_result_fifo_if: producer/consumer/debug signal bundle for the FP32 multiplier result FIFO.
interface fpmul_result_fifo_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int AW = $clog2(DEPTH);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      fp_z_in;
    logic             ovrf_in;
    logic             udrf_in;
    logic [2:0]       r_mode_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      fp_z_out;
    logic             ovrf_out;
    logic             udrf_out;
    logic [2:0]       r_mode_out;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             clr_cnt;
    logic [CNT_W-1:0] ovrf_cnt;
    logic [CNT_W-1:0] udrf_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, fp_z_in, ovrf_in, udrf_in, r_mode_in, out_ready, clr_cnt,
        input  in_ready, out_valid, fp_z_out, ovrf_out, udrf_out, r_mode_out,
               count, full, empty, ovrf_cnt, udrf_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, fp_z_in, ovrf_in, udrf_in, r_mode_in, out_ready, clr_cnt,
        output in_ready, out_valid, fp_z_out, ovrf_out, udrf_out, r_mode_out,
               count, full, empty, ovrf_cnt, udrf_cnt, stall_cnt
    );
endinterface

// File: rtl/fpmul_result_fifo.sv
// fpmul_result_fifo: first-word-fall-through FIFO capturing FP32 multiplier results,
// with saturating overflow/underflow/stall event counters.
module fpmul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    fpmul_result_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [37:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] ovrf_q, ovrf_d, udrf_q, udrf_d, stall_q, stall_d;
    logic             push, pop, full, empty, stall;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;
    assign stall = bus.in_valid && full;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovrf_d  = bus.clr_cnt ? '0 : (push && bus.ovrf_in && ovrf_q != '1) ? ovrf_q + 1'b1 : ovrf_q;
        udrf_d  = bus.clr_cnt ? '0 : (push && bus.udrf_in && udrf_q != '1) ? udrf_q + 1'b1 : udrf_q;
        stall_d = bus.clr_cnt ? '0 : (stall && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovrf_q  <= '0;
            udrf_q  <= '0;
            stall_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {bus.r_mode_in, bus.udrf_in, bus.ovrf_in, bus.fp_z_in};
    end

    assign {bus.r_mode_out, bus.udrf_out, bus.ovrf_out, bus.fp_z_out} = mem_q[rd_q];
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = cnt_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.ovrf_cnt  = ovrf_q;
    assign bus.udrf_cnt  = udrf_q;
    assign bus.stall_cnt = stall_q;

    a_no_push_full:  assert property (@(posedge clk) disable iff (rst) push |-> !full);
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
    a_count_bounded: assert property (@(posedge clk) disable iff (rst) cnt_q <= (AW+1)'(DEPTH));
endmodule

// File: tb/tb_fpmul_result_fifo.sv
// tb_fpmul_result_fifo: directed scenario tests for fpmul_result_fifo (DEPTH=4, CNT_W=4).
module tb_fpmul_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpmul_result_fifo_if #(.DEPTH(4), .CNT_W(4)) bus ();
    fpmul_result_fifo #(.DEPTH(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_cnt   = 1'b0;
        bus.ovrf_in   = 1'b0;
        bus.udrf_in   = 1'b0;
        bus.r_mode_in = 3'b000;
    endtask

    task automatic clear_counters();
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] z);
        bus.in_valid = 1'b1;
        bus.fp_z_in  = z;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [31:0] z);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.fp_z_out !== z) begin
            errors++;
            $display("FAIL %s: out_valid=%b fp_z_out=%h, required out_valid=1 fp_z_out=%h", name, bus.out_valid, bus.fp_z_out, z);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.fp_z_in = '0;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        step();
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0 ||
            bus.in_ready !== 1'b1 || bus.ovrf_cnt !== 4'd0 || bus.udrf_cnt !== 4'd0 || bus.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset: empty=%b full=%b out_valid=%b count=%0d in_ready=%b cnts=%0d/%0d/%0d, required 1 0 0 0 1 0/0/0",
                     bus.empty, bus.full, bus.out_valid, bus.count, bus.in_ready, bus.ovrf_cnt, bus.udrf_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_single_push();
        bus.r_mode_in = 3'b000;
        push_word(32'h3F800000);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.fp_z_out !== 32'h3F800000 || bus.count !== 3'd1 || bus.r_mode_out !== 3'b000 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL single_push: out_valid=%b fp_z_out=%h count=%0d r_mode=%b, required 1 3f800000 1 000",
                     bus.out_valid, bus.fp_z_out, bus.count, bus.r_mode_out);
        end
        pop_expect("single_pop", 32'h3F800000);
        checks++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: empty=%b out_valid=%b, required 1 0", bus.empty, bus.out_valid);
        end
    endtask

    task automatic test_full_stall();
        clear_counters();
        for (int i = 0; i < 4; i++) push_word(32'hA0000000 + i);
        checks++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL full: full=%b in_ready=%b count=%0d, required 1 0 4", bus.full, bus.in_ready, bus.count);
        end
        bus.in_valid = 1'b1;
        bus.fp_z_in  = 32'hA0000004;
        repeat (3) step();
        checks++;
        if (bus.stall_cnt !== 4'd3 || bus.full !== 1'b1 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL stall: stall_cnt=%0d full=%b count=%0d, required 3 1 4", bus.stall_cnt, bus.full, bus.count);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.fp_z_out !== 32'hA0000001 || bus.stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL first_pop: count=%0d in_ready=%b head=%h stall_cnt=%0d, required 3 1 a0000001 4",
                     bus.count, bus.in_ready, bus.fp_z_out, bus.stall_cnt);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd4 || bus.stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL fifth_accept: count=%0d stall_cnt=%0d, required 4 4", bus.count, bus.stall_cnt);
        end
        for (int i = 1; i < 5; i++) pop_expect("full_order", 32'hA0000000 + i);
    endtask

    task automatic test_push_pop_same_cycle();
        push_word(32'hB0000000);
        push_word(32'hB0000001);
        bus.in_valid  = 1'b1;
        bus.fp_z_in   = 32'hB0000002;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd2 || bus.fp_z_out !== 32'hB0000001) begin
            errors++;
            $display("FAIL push_pop: count=%0d head=%h, required 2 b0000001", bus.count, bus.fp_z_out);
        end
        pop_expect("push_pop_order", 32'hB0000001);
        pop_expect("push_pop_order", 32'hB0000002);
    endtask

    task automatic test_stream_wrap();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.fp_z_in  = 32'h40000000 + i;
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.fp_z_out !== 32'h40000000 + i || bus.count !== 3'd1) begin
                errors++;
                $display("FAIL stream[%0d]: out_valid=%b fp_z_out=%h count=%0d, required 1 %h 1",
                         i, bus.out_valid, bus.fp_z_out, bus.count, 32'h40000000 + i);
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_drain: empty=%b, required 1", bus.empty);
        end
    endtask

    task automatic test_counters();
        clear_counters();
        bus.ovrf_in   = 1'b1;
        bus.udrf_in   = 1'b1;
        bus.r_mode_in = 3'b101;
        push_word(32'h7F800000);
        checks++;
        if (bus.ovrf_out !== 1'b1 || bus.udrf_out !== 1'b1 || bus.r_mode_out !== 3'b101 || bus.ovrf_cnt !== 4'd1 || bus.udrf_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flags: ovrf_out=%b udrf_out=%b r_mode_out=%b cnts=%0d/%0d, required 1 1 101 1/1",
                     bus.ovrf_out, bus.udrf_out, bus.r_mode_out, bus.ovrf_cnt, bus.udrf_cnt);
        end
        pop_expect("flags_pop", 32'h7F800000);
        clear_counters();
        bus.udrf_in   = 1'b0;
        bus.r_mode_in = 3'b000;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hC0000000 + i);
        checks++;
        if (bus.ovrf_cnt !== 4'd3 || bus.udrf_cnt !== 4'd0) begin
            errors++;
            $display("FAIL ovrf_cnt: ovrf=%0d udrf=%0d, required 3 0", bus.ovrf_cnt, bus.udrf_cnt);
        end
        bus.clr_cnt = 1'b1;
        push_word(32'hC0000003);
        bus.clr_cnt = 1'b0;
        checks++;
        if (bus.ovrf_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_priority: ovrf_cnt=%0d, required 0", bus.ovrf_cnt);
        end
        bus.ovrf_in = 1'b0;
        bus.udrf_in = 1'b1;
        for (int i = 0; i < 20; i++) push_word(32'h00000001 + i);
        bus.udrf_in = 1'b0;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.udrf_cnt !== 4'd15 || bus.ovrf_cnt !== 4'd0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL udrf_saturate: udrf=%0d ovrf=%0d empty=%b, required 15 0 1", bus.udrf_cnt, bus.ovrf_cnt, bus.empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push_word(32'hD0000000 + i);
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: count=%0d, required 3", bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.udrf_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b count=%0d empty=%b udrf_cnt=%0d, required 0 0 1 0",
                     bus.out_valid, bus.count, bus.empty, bus.udrf_cnt);
        end
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_full_stall();
        test_push_pop_same_cycle();
        test_stream_wrap();
        test_counters();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
